// File: rtl/lineoblique_pkg.sv
// Shared types and constants for the oblique-line generator.
package lineoblique_pkg;

  localparam int unsigned X_W   = 11;
  localparam int unsigned Y_W   = 10;
  localparam int unsigned ERR_W = 13;

  localparam logic [23:0] DEFAULT_RGB = 24'hFFFFFF;
  localparam logic [23:0] MARK_RGB    = 24'hFF0000;

  typedef enum logic {StIdle, StRun} eng_state_e;

endpackage

// File: rtl/bresenham_step.sv
// Registered Bresenham engine: latches endpoints on frame_i while idle, then
// emits one pixel per clock until the end point is reached.
module bresenham_step
  import lineoblique_pkg::*;
(
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic           frame_i,
  input  logic [X_W-1:0] x_start_i,
  input  logic [Y_W-1:0] y_start_i,
  input  logic [X_W-1:0] x_end_i,
  input  logic [Y_W-1:0] y_end_i,
  output logic           start_o,
  output logic           busy_o,
  output logic           done_o,
  output logic [X_W-1:0] x_o,
  output logic [Y_W-1:0] y_o
);

  eng_state_e              state_q, state_d;
  logic [X_W-1:0]          x_q, x_d, xf_q, xf_d;
  logic [Y_W-1:0]          y_q, y_d, yf_q, yf_d;
  logic signed [ERR_W-1:0] dx_q, dx_d, dy_q, dy_d, err_q, err_d;
  logic                    sx_neg_q, sx_neg_d, sy_neg_q, sy_neg_d;

  logic [X_W-1:0]          dx_abs;
  logic [Y_W-1:0]          dy_abs;
  logic signed [ERR_W-1:0] dx_new, dy_new, e2;
  logic                    at_end;

  always_comb begin
    dx_abs = (x_end_i >= x_start_i) ? (x_end_i - x_start_i) : (x_start_i - x_end_i);
    dy_abs = (y_end_i >= y_start_i) ? (y_end_i - y_start_i) : (y_start_i - y_end_i);
    // Zero-extend magnitudes before the signed view; dy is kept negative.
    dx_new = signed'({{(ERR_W - X_W){1'b0}}, dx_abs});
    dy_new = -signed'({{(ERR_W - Y_W){1'b0}}, dy_abs});
    e2     = err_q <<< 1;
    at_end = (x_q == xf_q) && (y_q == yf_q);
  end

  always_comb begin
    state_d  = state_q;
    x_d      = x_q;
    y_d      = y_q;
    xf_d     = xf_q;
    yf_d     = yf_q;
    dx_d     = dx_q;
    dy_d     = dy_q;
    err_d    = err_q;
    sx_neg_d = sx_neg_q;
    sy_neg_d = sy_neg_q;
    start_o  = 1'b0;
    done_o   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (frame_i) begin
          start_o  = 1'b1;
          state_d  = StRun;
          x_d      = x_start_i;
          y_d      = y_start_i;
          xf_d     = x_end_i;
          yf_d     = y_end_i;
          dx_d     = dx_new;
          dy_d     = dy_new;
          err_d    = dx_new + dy_new;
          sx_neg_d = x_end_i < x_start_i;
          sy_neg_d = y_end_i < y_start_i;
        end
      end
      StRun: begin
        if (at_end) begin
          done_o  = 1'b1;
          state_d = StIdle;
        end else begin
          // Both decisions compare against the old err; updates accumulate.
          if (e2 >= dy_q) begin
            err_d = err_d + dy_q;
            x_d   = sx_neg_q ? (x_q - X_W'(1)) : (x_q + X_W'(1));
          end
          if (e2 <= dx_q) begin
            err_d = err_d + dx_q;
            y_d   = sy_neg_q ? (y_q - Y_W'(1)) : (y_q + Y_W'(1));
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= StIdle;
      x_q      <= '0;
      y_q      <= '0;
      xf_q     <= '0;
      yf_q     <= '0;
      dx_q     <= '0;
      dy_q     <= '0;
      err_q    <= '0;
      sx_neg_q <= 1'b0;
      sy_neg_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      x_q      <= x_d;
      y_q      <= y_d;
      xf_q     <= xf_d;
      yf_q     <= yf_d;
      dx_q     <= dx_d;
      dy_q     <= dy_d;
      err_q    <= err_d;
      sx_neg_q <= sx_neg_d;
      sy_neg_q <= sy_neg_d;
    end
  end

  assign busy_o = (state_q == StRun);
  assign x_o    = x_q;
  assign y_o    = y_q;

endmodule

// File: rtl/lineoblique_gen.sv
// Raster timing plus one Bresenham line per frame, drawn in LINE_RGB.
// Define LINEOBLIQUE_ENDPOINT_MARK_EN to paint the first and last pixels pure red.
module lineoblique_gen
  import lineoblique_pkg::*;
#(
  parameter int unsigned H_TOTAL  = 800,
  parameter int unsigned V_TOTAL  = 480,
  parameter logic [23:0] LINE_RGB = DEFAULT_RGB
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [X_W-1:0] x_offset,
  input  logic [Y_W-1:0] y_offset,
  input  logic [X_W-1:0] x_final,
  input  logic [Y_W-1:0] y_final,
  output logic [X_W-1:0] Xcount,
  output logic [Y_W-1:0] Ycount,
  output logic [X_W-1:0] Xline,
  output logic [Y_W-1:0] Yline,
  output logic           x_period,
  output logic           y_period,
  output logic           start_mark,
  output logic           done_mark,
  output logic           curseur,
  output logic [7:0]     red,
  output logic [7:0]     green,
  output logic [7:0]     blue
);

  logic [X_W-1:0] xcount_q, xcount_d;
  logic [Y_W-1:0] ycount_q, ycount_d;
  logic [23:0]    rgb;

  always_comb begin
    x_period = (xcount_q == X_W'(H_TOTAL - 1));
    y_period = x_period && (ycount_q == Y_W'(V_TOTAL - 1));
    xcount_d = x_period ? '0 : (xcount_q + X_W'(1));
    ycount_d = ycount_q;
    if (x_period) begin
      ycount_d = y_period ? '0 : (ycount_q + Y_W'(1));
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      xcount_q <= '0;
      ycount_q <= '0;
    end else begin
      xcount_q <= xcount_d;
      ycount_q <= ycount_d;
    end
  end

  bresenham_step u_engine (
    .clk_i     (clk),
    .rst_i     (reset),
    .frame_i   (y_period),
    .x_start_i (x_offset),
    .y_start_i (y_offset),
    .x_end_i   (x_final),
    .y_end_i   (y_final),
    .start_o   (start_mark),
    .busy_o    (curseur),
    .done_o    (done_mark),
    .x_o       (Xline),
    .y_o       (Yline)
  );

`ifdef LINEOBLIQUE_ENDPOINT_MARK_EN
  // The first pixel is always the cycle right after start_mark.
  logic first_q;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) first_q <= 1'b0;
    else       first_q <= start_mark;
  end
`endif

  always_comb begin
    rgb = '0;
    if (curseur) begin
      rgb = LINE_RGB;
`ifdef LINEOBLIQUE_ENDPOINT_MARK_EN
      if (first_q || done_mark) rgb = MARK_RGB;
`endif
    end
  end

  assign Xcount = xcount_q;
  assign Ycount = ycount_q;
  assign {red, green, blue} = rgb;

endmodule

// File: tb/tb_lineoblique_gen.sv
// Directed, table-driven bench for lineoblique_gen on a 16x4 raster.
module tb_lineoblique_gen;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [10:0] x_offset, x_final, Xcount, Xline;
  logic [9:0]  y_offset, y_final, Ycount, Yline;
  logic        x_period, y_period, start_mark, done_mark, curseur;
  logic [7:0]  red, green, blue;

  lineoblique_gen #(
    .H_TOTAL (16),
    .V_TOTAL (4)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .x_offset   (x_offset),
    .y_offset   (y_offset),
    .x_final    (x_final),
    .y_final    (y_final),
    .Xcount     (Xcount),
    .Ycount     (Ycount),
    .Xline      (Xline),
    .Yline      (Yline),
    .x_period   (x_period),
    .y_period   (y_period),
    .start_mark (start_mark),
    .done_mark  (done_mark),
    .curseur    (curseur),
    .red        (red),
    .green      (green),
    .blue       (blue)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [10:0] xo;
    logic [9:0]  yo;
    logic [10:0] xf;
    logic [9:0]  yf;
    int          n;
    int          base;
    bit          scramble;
  } line_t;

  typedef struct {
    logic [10:0] x;
    logic [9:0]  y;
  } pix_t;

  line_t lines[$];
  pix_t  pix[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic add_line(input int xo, input int yo, input int xf, input int yf,
                          input int n, input bit scramble);
    line_t l;
    l.xo = 11'(xo); l.yo = 10'(yo); l.xf = 11'(xf); l.yf = 10'(yf);
    l.n = n; l.base = pix.size(); l.scramble = scramble;
    lines.push_back(l);
  endtask

  task automatic add_pix(input int x, input int y);
    pix_t p;
    p.x = 11'(x); p.y = 10'(y);
    pix.push_back(p);
  endtask

  task automatic wait_start(output int cycles);
    cycles = 0;
    while (!start_mark && cycles < 200) begin
      @(negedge clk);
      cycles++;
    end
    check("start_mark_seen", 32'(start_mark), 32'd1);
  endtask

  task automatic run_line(input line_t l);
    int          cyc;
    logic [23:0] exp_rgb;
    @(negedge clk);
    x_offset = l.xo; y_offset = l.yo; x_final = l.xf; y_final = l.yf;
    wait_start(cyc);
    if (!start_mark) return;
    check("start_on_y_period", 32'(y_period), 32'd1);
    check("idle_before_start", 32'(curseur), 32'd0);
    for (int k = 0; k < l.n; k++) begin
      @(negedge clk);
      // Endpoint inputs are only sampled at start_mark; junk here must not matter.
      if (l.scramble && k == 0) begin
        x_offset = 11'd100; y_offset = 10'd200; x_final = 11'd3; y_final = 10'd7;
      end
      exp_rgb = 24'hFFFFFF;
`ifdef LINEOBLIQUE_ENDPOINT_MARK_EN
      if (k == 0 || k == l.n - 1) exp_rgb = 24'hFF0000;
`endif
      check("curseur", 32'(curseur), 32'd1);
      check("Xline", 32'(Xline), 32'(pix[l.base + k].x));
      check("Yline", 32'(Yline), 32'(pix[l.base + k].y));
      check("done_mark", 32'(done_mark), (k == l.n - 1) ? 32'd1 : 32'd0);
      check("rgb", 32'({red, green, blue}), 32'(exp_rgb));
    end
    @(negedge clk);
    check("curseur_after", 32'(curseur), 32'd0);
    check("rgb_after", 32'({red, green, blue}), 32'd0);
  endtask

  initial begin
    int cyc;

    add_line(15, 0, 10, 9, 10, 1'b1);
    add_pix(15, 0); add_pix(14, 1); add_pix(14, 2); add_pix(13, 3); add_pix(13, 4);
    add_pix(12, 5); add_pix(12, 6); add_pix(11, 7); add_pix(11, 8); add_pix(10, 9);
    add_line(3, 0, 12, 4, 10, 1'b0);
    add_pix(3, 0); add_pix(4, 0); add_pix(5, 1); add_pix(6, 1); add_pix(7, 2);
    add_pix(8, 2); add_pix(9, 3); add_pix(10, 3); add_pix(11, 4); add_pix(12, 4);
    add_line(5, 5, 5, 5, 1, 1'b0);
    add_pix(5, 5);
    add_line(2, 1, 6, 1, 5, 1'b0);
    add_pix(2, 1); add_pix(3, 1); add_pix(4, 1); add_pix(5, 1); add_pix(6, 1);
    add_line(7, 3, 7, 0, 4, 1'b0);
    add_pix(7, 3); add_pix(7, 2); add_pix(7, 1); add_pix(7, 0);
    add_line(0, 0, 3, 3, 4, 1'b0);
    add_pix(0, 0); add_pix(1, 1); add_pix(2, 2); add_pix(3, 3);

    x_offset = '0; y_offset = '0; x_final = '0; y_final = '0;
    reset = 1'b1;
    #1;
    check("rst_Xcount", 32'(Xcount), 32'd0);
    check("rst_curseur", 32'(curseur), 32'd0);
    #41;
    check("rst_Xcount_held", 32'(Xcount), 32'd0);
    check("rst_Ycount_held", 32'(Ycount), 32'd0);
    check("rst_Xline", 32'(Xline), 32'd0);
    check("rst_rgb", 32'({red, green, blue}), 32'd0);
    check("rst_marks", 32'({start_mark, done_mark}), 32'd0);
    #8 reset = 1'b0;
    #1 check("Xcount_after_release", 32'(Xcount), 32'd0);
    repeat (15) @(posedge clk);
    #1;
    check("Xcount_last", 32'(Xcount), 32'd15);
    check("x_period_high", 32'(x_period), 32'd1);
    check("y_period_low", 32'(y_period), 32'd0);
    @(posedge clk);
    #1;
    check("Xcount_wrap", 32'(Xcount), 32'd0);
    check("Ycount_step", 32'(Ycount), 32'd1);
    check("x_period_low", 32'(x_period), 32'd0);

    foreach (lines[i]) run_line(lines[i]);

    // Abort a line mid-run with an asynchronous reset.
    @(negedge clk);
    x_offset = 11'd15; y_offset = 10'd0; x_final = 11'd10; y_final = 10'd9;
    wait_start(cyc);
    repeat (3) @(negedge clk);
    check("mid_run_curseur", 32'(curseur), 32'd1);
    #2 reset = 1'b1;
    #1;
    check("abort_curseur", 32'(curseur), 32'd0);
    check("abort_rgb", 32'({red, green, blue}), 32'd0);
    check("abort_Xline", 32'(Xline), 32'd0);
    check("abort_Xcount", 32'(Xcount), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    wait_start(cyc);
    check("restart_latency", 32'(cyc), 32'd63);
    check("restart_Xcount", 32'(Xcount), 32'd15);
    check("restart_Ycount", 32'(Ycount), 32'd3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/lineoblique_gen.md
Name: lineoblique_gen

Overview:
- Oblique-line pixel generator for the display path.
- Contains a free-running raster counter (Xcount/Ycount) that provides frame timing, plus a Bresenham engine.
- The Bresenham engine emits one line pixel (Xline/Yline) per clock, from (x_offset,y_offset) to (x_final,y_final), once per frame.
- Drives RGB white while a line pixel is valid; feeds the pixel-write and overlay logic downstream.

Parameters:
- H_TOTAL, 800, raster columns per line (Xcount wraps at H_TOTAL-1).
- V_TOTAL, 480, raster lines per frame (Ycount wraps at V_TOTAL-1).
- LINE_RGB, 24'hFFFFFF, colour driven while curseur is high.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- x_offset  in  11  line start X.
- y_offset  in  10  line start Y.
- x_final  in  11  line end X.
- y_final  in  10  line end Y.
- Xcount  out  11  raster column counter.
- Ycount  out  10  raster line counter.
- Xline  out  11  current line pixel X.
- Yline  out  10  current line pixel Y.
- x_period  out  1  high when Xcount==H_TOTAL-1.
- y_period  out  1  high when Xcount==H_TOTAL-1 and Ycount==V_TOTAL-1.
- start_mark  out  1  one-cycle pulse: endpoints latched, engine starts.
- done_mark  out  1  one-cycle pulse: final pixel emitted.
- curseur  out  1  Xline/Yline hold a valid line pixel this cycle.
- red, green, blue  out  8 each  pixel colour.

Behaviour:
- Reset (asynchronous, active-high):
  - All counters and outputs go to 0; the engine is IDLE.
  - No line is drawn until the first frame wrap.
- Raster counter:
  - Xcount increments every clk and wraps to 0 after H_TOTAL-1.
  - Ycount increments on each X wrap and wraps to 0 after V_TOTAL-1.
  - x_period and y_period are combinational decodes of the counters.
- Engine states: IDLE, RUN.
- IDLE -> RUN on the cycle y_period is high:
  - start_mark=1 that cycle.
  - Latch all four endpoint inputs.
  - Compute dx=|xf-xo|, dy=-|yf-yo|, sx=sign(xf-xo), sy=sign(yf-yo), err=dx+dy.
  - Load Xline=xo, Yline=yo.
- RUN, every cycle:
  - curseur=1 with the current pixel.
  - If Xline==xf and Yline==yf: done_mark=1, next state IDLE.
  - Otherwise e2=2*err:
    - if e2>=dy: err+=dy, Xline+=sx
    - if e2<=dx: err+=dx, Yline+=sy
    - both updates use the old err and may occur in the same cycle.
- Pixel count per frame is max(dx,|dy|)+1.
- First pixel appears 1 cycle after start_mark.
- done_mark coincides with the last pixel.
- Arithmetic:
  - err and e2 are signed 13 bits, so there is no overflow for 11/10-bit coordinates.
  - Sign extension is explicit; Xline/Yline never leave the endpoint bounding box.
- Boundary cases:
  - Degenerate line (start==end): one pixel; start_mark is followed one cycle later by done_mark with curseur high.
  - Horizontal, vertical and 45° lines use the same rules.
- y_period during RUN (line longer than a frame): ignored; the current line completes and the next start waits for the following y_period.
- Endpoint inputs may change at any time; they are sampled only at start_mark.
- red/green/blue = LINE_RGB when curseur, else 0. Registered alongside curseur, no extra latency.
- Reset mid-line aborts immediately to IDLE with all outputs 0.

Optional Feature:
- Macro LINEOBLIQUE_ENDPOINT_MARK_EN.
- Defined: the first and last line pixels are driven pure red (FF,00,00) instead of LINE_RGB.
- Undefined: every pixel uses LINE_RGB.
- Timing and the other outputs are identical in both cases.

Decomposition:
- Package lineoblique_pkg:
  - engine state enum (IDLE, RUN)
  - coordinate widths (X_W=11, Y_W=10, ERR_W=13)
  - default colour constant
- One sub-module, bresenham_step: registered Bresenham engine (latch, step, done).
- The raster counter and colour mux stay in the top level.

Test Plan:
- Reset held 50 ns then released:
  - all outputs 0 while reset is high;
  - Xcount counts from 0 after release;
  - x_period high at Xcount=H_TOTAL-1.
- Start (15,0), end (10,9), small H_TOTAL/V_TOTAL:
  - after y_period, start_mark, then 10 pixels:
    (15,0)(14,1)(14,2)(13,3)(13,4)(12,5)(12,6)(11,7)(11,8)(10,9);
  - done_mark with (10,9);
  - curseur high exactly 10 cycles.
- Start (3,0), end (12,4):
  - 10 pixels, Xline +1 each cycle, Yline 0..4;
  - done_mark at (12,4).
- Start=end=(5,5):
  - single pixel;
  - done_mark one cycle after start_mark;
  - RGB=FFFFFF for one cycle.
- Async reset asserted mid-RUN:
  - curseur/RGB drop to 0 without a clock edge;
  - after release, the next line starts only at the next y_period.
- LINEOBLIQUE_ENDPOINT_MARK_EN defined, run (3,0)->(12,4):
  - first and last pixels are FF0000;
  - interior pixels are FFFFFF.
